// File: rtl/code_fetch.sv
// Instruction fetch stage: walks a pc through code RAM, absorbs the one-cycle
// read latency and hands words downstream through a small show-ahead FIFO.
module code_fetch #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              running,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_write,
  input  logic [DATA_W-1:0] ram_read,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, FETCH} state_t;
  state_t state_reg, state_next;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              inflight_reg, inflight_next;
  logic [ADDR_W-1:0] inflight_addr_reg, inflight_addr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic flush, push, pop;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    inflight_next      = 1'b0;
    inflight_addr_next = inflight_addr_reg;
    flush              = 1'b0;
    push               = 1'b0;
    case (state_reg)
      IDLE: begin
        pc_next = '0;
        if (running) state_next = FETCH;
      end
      FETCH: begin
        if (!running) begin
          state_next = IDLE;
          pc_next    = '0;
          flush      = 1'b1;
        end else if (redirect_valid) begin
          // The word in flight belongs to the old stream and is dropped.
          pc_next = redirect_addr;
          flush   = 1'b1;
        end else begin
          push = inflight_reg;
          // Reserve a slot for the in-flight word; pops this cycle earn no credit.
          if ((count_reg + CNT_W'(inflight_reg)) < CNT_W'(DEPTH)) begin
            pc_next            = pc_reg + ADDR_W'(1);
            inflight_next      = 1'b1;
            inflight_addr_next = pc_reg;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pop = instr_valid && instr_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      pc_reg            <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      inflight_reg      <= inflight_next;
      inflight_addr_reg <= inflight_addr_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= ram_read;
      addr_mem[wr_ptr_reg] <= inflight_addr_reg;
    end
  end

  // Head words are masked while empty so outputs read zero out of reset.
  assign instr_valid = (count_reg != '0);
  assign instr_data  = instr_valid ? data_mem[rd_ptr_reg] : '0;
  assign instr_addr  = instr_valid ? addr_mem[rd_ptr_reg] : '0;
  assign ram_addr    = pc_reg;
  assign ram_we      = 1'b0;
  assign ram_write   = '0;
  assign busy        = (state_reg == FETCH);
endmodule
